// File: rtl/eae_pkg.sv
// Shared definitions for the EAE multiply and divide units: word width,
// sequencer state encoding and iteration count.
package eae_pkg;

  localparam int WORD_W   = 12;
  localparam int EAE_ITER = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } eae_state_t;

endpackage

// File: rtl/eae_multiply.sv
// Sequential shift-add multiplier for MUY: AC:MQ <= MQ * operand + AC.
// One multiplier bit per clock, with the start/finished handshake shared with divide.
module eae_multiply #(
  parameter int WORD_W = eae_pkg::WORD_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] multiplicand,
  input  logic [WORD_W-1:0] multiplier,
  input  logic [WORD_W-1:0] addend,
  output logic [WORD_W-1:0] product_high,
  output logic [WORD_W-1:0] product_low,
  output logic              link_out,
  output logic              busy,
  output logic              finished
);
  import eae_pkg::*;

  localparam int CNT_W = $clog2(EAE_ITER);

  eae_state_t          r_state;
  logic [WORD_W-1:0]   r_regm;
  logic [2*WORD_W-1:0] r_regp;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_link;
  logic [WORD_W:0]     w_sum;

  // Preloading the addend into the upper half makes the add fall out of the
  // iterations for free; the carry of each partial sum shifts into the MSB.
  assign w_sum = {1'b0, r_regp[2*WORD_W-1:WORD_W]}
               + (r_regp[0] ? {1'b0, r_regm} : {(WORD_W+1){1'b0}});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_regm  <= '0;
      r_regp  <= '0;
      r_cnt   <= '0;
      r_link  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_regm  <= multiplicand;
            r_regp  <= {addend, multiplier};
            r_cnt   <= '0;
            r_link  <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_regp <= {w_sum, r_regp[WORD_W-1:1]};
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(EAE_ITER - 1)) r_state <= DONE;
        end
        DONE: r_state <= start ? HOLD : IDLE;
        HOLD: if (!start) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign product_high = r_regp[2*WORD_W-1:WORD_W];
  assign product_low  = r_regp[WORD_W-1:0];
  assign link_out     = r_link;
  assign busy         = (r_state == RUN);
  assign finished     = (r_state == DONE);

endmodule

// File: tb/tb_eae_multiply.sv
// Self-checking bench for eae_multiply: scoreboard of expected AC:MQ results
// filled at launch and drained when finished strobes.
module tb_eae_multiply;
  localparam int W = 12;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] multiplicand, multiplier, addend;
  logic [W-1:0] product_high, product_low;
  logic         link_out, busy, finished;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  eae_multiply #(.WORD_W(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier), .addend(addend),
    .product_high(product_high), .product_low(product_low),
    .link_out(link_out), .busy(busy), .finished(finished)
  );

  always #5 clock = ~clock;

  // Drive one start pulse and record the arithmetic result; returns at the
  // falling edge right after the loading edge.
  task automatic launch(input logic [W-1:0] m, input logic [W-1:0] q, input logic [W-1:0] a);
    logic [2*W-1:0] e;
    @(negedge clock);
    multiplicand = m; multiplier = q; addend = a; start = 1'b1;
    e = (2*W)'(m) * (2*W)'(q) + (2*W)'(a);
    exp_q.push_back(e);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Counts cycles from the loading edge until finished, bounded.
  task automatic wait_finished(output int lat);
    lat = 1;
    while (!finished && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0;
    multiplicand = '0; multiplier = '0; addend = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({product_high, product_low, link_out, busy, finished} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ph=%h pl=%h l=%b b=%b f=%b want all 0",
               product_high, product_low, link_out, busy, finished);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic(input logic [W-1:0] m, input logic [W-1:0] q, input logic [W-1:0] a, input string nm);
    int lat;
    logic [2*W-1:0] e;
    launch(m, q, a);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy got %b want 1", nm, busy); end
    wait_finished(lat);
    checks++;
    if (!finished || lat != 13) begin
      errors++; $display("FAIL %s_latency got %0d (finished=%b) want 13", nm, lat, finished);
    end
    e = exp_q.pop_front();
    checks++;
    if ({product_high, product_low} !== e || link_out !== 1'b0) begin
      errors++;
      $display("FAIL %s_result got %h_%h link=%b want %h_%h link=0", nm, product_high, product_low, link_out, e[2*W-1:W], e[W-1:0]);
    end
    @(negedge clock);
    checks++;
    if (finished !== 1'b0) begin errors++; $display("FAIL %s_strobe_width got finished=%b want 0", nm, finished); end
  endtask

  task automatic test_stable;
    logic [2*W-1:0] e;
    int lat;
    launch(12'h010, 12'h123, 12'h000);
    wait_finished(lat);
    e = exp_q.pop_front();
    checks++;
    if ({product_high, product_low} !== 24'h001230 || e !== 24'h001230) begin
      errors++; $display("FAIL stable_result got %h_%h want 001_230", product_high, product_low);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++;
      if ({product_high, product_low} !== e) begin
        errors++; $display("FAIL stable_hold cycle %0d got %h_%h want %h", i, product_high, product_low, e);
      end
    end
  endtask

  task automatic test_held_start;
    int pulses = 0;
    int later = 0;
    logic [2*W-1:0] got = '0;
    logic [2*W-1:0] e;
    @(negedge clock);
    multiplicand = 12'd7; multiplier = 12'd9; addend = 12'd1; start = 1'b1;
    exp_q.push_back(24'd64);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (finished) begin pulses++; got = {product_high, product_low}; end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL held_pulses got %0d want 1", pulses); end
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin errors++; $display("FAIL held_result got %h want %h", got, e); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL held_hold_busy got %b want 0", busy); end
    multiplicand = 12'd3;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (finished || busy) later++;
    end
    checks++;
    if (later != 0) begin errors++; $display("FAIL held_relaunch got %0d active cycles want 0", later); end
    checks++;
    if ({product_high, product_low} !== e) begin
      errors++; $display("FAIL held_outputs got %h_%h want %h", product_high, product_low, e);
    end
  endtask

  task automatic test_start_toggle;
    int lat;
    logic [2*W-1:0] e;
    launch(12'h0AB, 12'h0CD, 12'h011);
    lat = 1;
    while (!finished && lat < 40) begin
      start = (lat < 9) ? lat[0] : 1'b0;
      multiplicand = W'($urandom_range(0, 4095));
      multiplier   = W'($urandom_range(0, 4095));
      addend       = W'($urandom_range(0, 4095));
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!finished || lat != 13) begin
      errors++; $display("FAIL toggle_latency got %0d (finished=%b) want 13", lat, finished);
    end
    checks++;
    if ({product_high, product_low} !== e) begin
      errors++; $display("FAIL toggle_result got %h_%h want %h", product_high, product_low, e);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_run;
    logic [2*W-1:0] discard;
    launch(12'h03F, 12'h02A, 12'h005);
    repeat (5) @(negedge clock);
    discard = exp_q.pop_front();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({product_high, product_low, link_out, busy, finished} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got ph=%h pl=%h l=%b b=%b f=%b want all 0 (abandoned %h)",
               product_high, product_low, link_out, busy, finished, discard);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (finished !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_idle got busy=%b finished=%b want 0 0", busy, finished);
    end
    reset_n = 1'b1;
    test_basic(12'd2, 12'd2, 12'd0, "after_reset");
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [2*W-1:0] e;
    logic [W-1:0] ms[3] = '{12'h123, 12'hFFF, 12'h800};
    logic [W-1:0] qs[3] = '{12'h456, 12'h001, 12'h002};
    logic [W-1:0] as[3] = '{12'h789, 12'h000, 12'hFFF};
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      launch(ms[k], qs[k], as[k]);
      wait_finished(lat);
      checks++;
      if (!finished || lat != 13) begin
        errors++; $display("FAIL b2b_latency op %0d got %0d want 13", k, lat);
      end
      e = exp_q.pop_front();
      checks++;
      if ({product_high, product_low} !== e) begin
        errors++; $display("FAIL b2b_result op %0d got %h_%h want %h", k, product_high, product_low, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic(12'd5, 12'd3, 12'd7, "basic");
    test_basic(12'hFFF, 12'hFFF, 12'hFFF, "max");
    test_stable();
    test_held_start();
    test_start_toggle();
    test_reset_mid_run();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eae_multiply.md
# eae_multiply

Sequential 12×12 shift-add multiplier for the extended arithmetic element. It is the counterpart of the EAE divide unit and implements MUY: (MQ × operand) + AC into a 24-bit AC:MQ result. The instruction sequencer drives it with the same start/finished handshake it uses for divide, so both units can share one control path. One multiplier bit is processed per clock over 12 iterations.

## Interface
- `WORD_W`, 12, word width; product is 2×`WORD_W`.
- `clock` in 1, sole clock, rising edge.
- `reset_n` in 1, asynchronous active-low reset.
- `start` in 1, request; sampled only in IDLE.
- `multiplicand` in `WORD_W`, memory operand; captured at load.
- `multiplier` in `WORD_W`, MQ; captured at load.
- `addend` in `WORD_W`, AC; captured at load and added to the product.
- `product_high` out `WORD_W`, result bits [23:12], the new AC.
- `product_low` out `WORD_W`, result bits [11:0], the new MQ.
- `link_out` out 1, link result; always 0 after a multiply.
- `busy` out 1, high in RUN.
- `finished` out 1, one-cycle done strobe.

## Operation
- **Registers**
  - `regm[WORD_W-1:0]`: multiplicand.
  - `regp[2·WORD_W-1:0]`: accumulator/multiplier.
  - Iteration counter: 0..11.
  - State register.
- **Load** (IDLE with `start`=1):
  - `regm` ← `multiplicand`.
  - `regp` ← {`addend`, `multiplier`}.
  - Counter ← 0.
  - `link_out` ← 0.
- **Iteration** (RUN, one per clock):
  - `sum[WORD_W:0]` = {0, `regp[23:12]`} + (`regp[0]` ? {0, `regm`} : 0).
  - `regp` ← {`sum`, `regp[11:1]`}, i.e. a 25-bit value shifted right by 1.
  - The carry out of `sum` lands in `regp[23]`.
- **Width rule**: the final value is exactly `multiplier`×`multiplicand`+`addend`.
  - Maximum is 4095×4095+4095 = 0xFFF000, which cannot overflow 24 bits.
- **States**
  - IDLE: if `start`, load and go to RUN; otherwise stay.
  - RUN: `busy`=1; iterate and increment the counter. When the counter is 11, go to DONE after that iteration.
  - DONE: `finished`=1 for exactly one cycle. If `start`=0, go to IDLE; otherwise go to HOLD.
  - HOLD: wait until `start`=0, then go to IDLE. A held `start` never relaunches the unit.
  - Any illegal encoding: go to IDLE.
- **Output stability**: `product_*` show `regp` at all times. They change only during RUN and remain stable from DONE until the next load.
- **`start` outside IDLE**: ignored during RUN, DONE and HOLD.

## Timing
- **Reset values** (`reset_n`=0, asynchronous):
  - State IDLE.
  - `regp`, `regm` and counter all 0.
  - `product_high`=0, `product_low`=0, `link_out`=0, `busy`=0, `finished`=0.
- **Reset mid-RUN**: the operation is abandoned with no `finished` pulse. The unit is in IDLE on the first edge after `reset_n` rises.
- **Latency**:
  - Edge E0 samples `start`=1 in IDLE and loads.
  - Edges E1..E12 perform the 12 iterations; `busy` is high from E0 to E12.
  - State is DONE after E12, so `finished` is high in the cycle following E12 with the result valid.
  - Start-edge to `finished` is 13 cycles.
- **Back-to-back**: with `start` dropped during DONE, the next start can be sampled at the edge ending the IDLE cycle. Minimum issue interval is 14 cycles.
- **Output decode**: `finished` and `busy` are decoded from registered state only, with no combinational path from inputs.

## Structure
- Package `eae_pkg`, shared with the divide unit:
  - `WORD_W` constant.
  - State typedef `eae_state_t` {IDLE, RUN, DONE, HOLD}.
  - Iteration count constant `EAE_ITER` = 12.
- Single module with no sub-modules. The adder is one inline `WORD_W+1`-bit expression.

## Test plan
- `multiplicand`=5, `multiplier`=3, `addend`=7, `start` pulse → after 13 cycles `finished`=1 with `product_high`=0x000, `product_low`=0x016, `link_out`=0.
- `multiplicand`=0xFFF, `multiplier`=0xFFF, `addend`=0xFFF → `product_high`=0xFFF, `product_low`=0x000.
- `multiplicand`=0x010, `multiplier`=0x123, `addend`=0 → `product_high`=0x001, `product_low`=0x230. Outputs stay unchanged for 20 idle cycles afterward.
- `start` held high for 40 cycles → exactly one `finished` pulse, then HOLD. After `start` falls there is no second operation until a new rise.
- `start` toggled during RUN with different operands → no effect; the result matches the first operands.
- `reset_n` asserted at iteration 6 → all outputs 0 immediately with no `finished`. A subsequent start of 2×2+0 gives `product_low`=0x004.
